// File: rtl/clock_time_if.sv
// clock_time_if: groups the time sequencer's pulse inputs and display outputs.
//   tick_1hz, btn_mode, btn_inc : 1-cycle pulses into the sequencer
//   hours[4:0], minutes[5:0], seconds[5:0] : current time of day
//   mode[1:0] : 0 = RUN, 1 = SET_HOUR, 2 = SET_MIN
//   blink : flash phase of the field being edited
//   day_wrap : 1-cycle pulse on midnight rollover
// The master modport is the stimulus side. The slave modport is the sequencer.
interface clock_time_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;
    logic       day_wrap;

    modport master (
        output tick_1hz, btn_mode, btn_inc,
        input  hours, minutes, seconds, mode, blink, day_wrap
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc,
        output hours, minutes, seconds, mode, blink, day_wrap
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: time-of-day sequencer with a hour/minute edit mode.
//   clk, rst_n : system clock and asynchronous active-low reset
//   bus (clock_time_if.slave) :
//     in  tick_1hz, btn_mode, btn_inc
//     out hours, minutes, seconds, mode, blink, day_wrap (all registered)
// In RUN, each tick advances hh:mm:ss. btn_mode steps the mode
// RUN -> SET_HOUR -> SET_MIN -> RUN. While editing, time is frozen and
// ticks only toggle blink. Leaving SET_MIN zeroes the seconds.
module clock_time_ctrl #(
    parameter int unsigned HOURS_PER_DAY = 24,
    parameter int unsigned INIT_HOUR     = 0,
    parameter int unsigned INIT_MIN      = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    clock_time_if.slave   bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_e;

    localparam logic [4:0] HOUR_LAST = 5'(HOURS_PER_DAY - 1);
    localparam logic [4:0] HOUR_INIT = 5'(INIT_HOUR);
    localparam logic [5:0] MIN_INIT  = 6'(INIT_MIN);
    localparam logic [5:0] SIXTY_M1  = 6'd59;

    state_e     state_q, state_d;
    logic [4:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic       blink_q, blink_d;
    logic       day_wrap_q, day_wrap_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            hours_q    <= HOUR_INIT;
            minutes_q  <= MIN_INIT;
            seconds_q  <= 6'd0;
            blink_q    <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            blink_q    <= blink_d;
            day_wrap_q <= day_wrap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        blink_d    = blink_q;
        day_wrap_d = 1'b0;

        case (state_q)
            RUN: begin
                // A tick still lands when btn_mode arrives in the same cycle.
                if (bus.tick_1hz) begin
                    if (seconds_q == SIXTY_M1) begin
                        seconds_d = 6'd0;
                        if (minutes_q == SIXTY_M1) begin
                            minutes_d = 6'd0;
                            if (hours_q == HOUR_LAST) begin
                                hours_d    = 5'd0;
                                day_wrap_d = 1'b1;
                            end else begin
                                hours_d = hours_q + 5'd1;
                            end
                        end else begin
                            minutes_d = minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_d = seconds_q + 6'd1;
                    end
                end
                if (bus.btn_mode) begin
                    state_d = SET_HOUR;
                    blink_d = 1'b0;
                end
            end
            SET_HOUR: begin
                // btn_mode takes priority. Any inc or tick in that cycle is dropped.
                if (bus.btn_mode) begin
                    state_d = SET_MIN;
                    blink_d = 1'b0;
                end else begin
                    if (bus.tick_1hz) blink_d = ~blink_q;
                    if (bus.btn_inc)
                        hours_d = (hours_q == HOUR_LAST) ? 5'd0 : hours_q + 5'd1;
                end
            end
            SET_MIN: begin
                if (bus.btn_mode) begin
                    state_d   = RUN;
                    blink_d   = 1'b0;
                    seconds_d = 6'd0;
                end else begin
                    if (bus.tick_1hz) blink_d = ~blink_q;
                    if (bus.btn_inc)
                        minutes_d = (minutes_q == SIXTY_M1) ? 6'd0 : minutes_q + 6'd1;
                end
            end
            default: begin
                state_d = RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    assign bus.hours    = hours_q;
    assign bus.minutes  = minutes_q;
    assign bus.seconds  = seconds_q;
    assign bus.mode     = state_q;
    assign bus.blink    = blink_q;
    assign bus.day_wrap = day_wrap_q;
endmodule
